// File: rtl/noc_pkg.sv
// Shared types and helpers for the virtual-channel egress mux.
package noc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1, so single-entry selectors still get a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/noc_vchannel_fifo.sv
// Single-channel flit FIFO that also counts the complete packets it holds.
module noc_vchannel_fifo
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int FW         = clog2_min1(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [FLIT_WIDTH-1:0] push_flit,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [FLIT_WIDTH-1:0] head_flit,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty,
    output logic [FW-1:0]         fill,
    output logic [FW-1:0]         lcnt
);

    localparam int AW = $clog2(DEPTH);

    logic [FLIT_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [FW-1:0]       count, lcnt_q;
    logic                do_push, do_pop, push_l, pop_l;

    assign full    = (count == FW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign push_l  = do_push && push_last;
    assign pop_l   = do_pop && head_last;
    assign fill    = count;
    assign lcnt    = lcnt_q;

    assign {head_last, head_flit} = mem[rd_ptr];

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_last, push_flit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lcnt_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_l && !pop_l)      lcnt_q <= lcnt_q + 1'b1;
            else if (pop_l && !push_l) lcnt_q <= lcnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/noc_vchannel_buffer_mux.sv
// Buffers CHANNELS flit streams and merges them packet-atomically, round-robin,
// onto one link.
module noc_vchannel_buffer_mux
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 4,
    parameter int FULLPACKET = 0,
    localparam int CW        = clog2_min1(CHANNELS),
    localparam int FW        = clog2_min1(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [CHANNELS-1:0]                  in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [FLIT_WIDTH-1:0]                out_flit,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CW-1:0]                        out_channel,
    output logic [CHANNELS-1:0][FW-1:0]          fill
);

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    flit_t [CHANNELS-1:0]         head_flit;
    logic  [CHANNELS-1:0]         head_last, full, empty, elig, pop;
    logic  [CHANNELS-1:0][FW-1:0] lcnt;

    arb_state_e    state, state_n;
    logic [CW-1:0] sel, sel_n, rr_ptr, rr_n, pick, cand;
    logic          found, xfer;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        noc_vchannel_fifo #(
            .FLIT_WIDTH(FLIT_WIDTH),
            .DEPTH     (DEPTH),
            .FW        (FW)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (in_valid[c] && in_ready[c]),
            .push_flit(in_flit[c]),
            .push_last(in_last[c]),
            .pop      (pop[c]),
            .head_flit(head_flit[c]),
            .head_last(head_last[c]),
            .full     (full[c]),
            .empty    (empty[c]),
            .fill     (fill[c]),
            .lcnt     (lcnt[c])
        );

        assign in_ready[c] = !full[c] && !rst;
        // Store-and-forward waits for a whole packet, unless the packet cannot fit.
        assign elig[c]     = (FULLPACKET != 0) ? ((lcnt[c] != '0) || full[c]) : !empty[c];
        assign pop[c]      = xfer && (sel == CW'(c));
    end

    always_comb begin
        pick  = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = CW'((int'(rr_ptr) + i) % CHANNELS);
            if (!found && elig[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign out_valid   = (state == LOCKED) && !empty[sel];
    assign xfer        = out_valid && out_ready;
    assign out_flit    = out_valid ? head_flit[sel] : '0;
    assign out_last    = out_valid && head_last[sel];
    assign out_channel = sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= CW'(CHANNELS - 1);
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            rr_ptr <= rr_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        rr_n    = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_n   = pick;
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                // Stay locked through mid-packet underflow; release only on last.
                if (xfer && head_last[sel]) begin
                    rr_n    = sel;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_noc_vchannel_buffer_mux.sv
// Scoreboard bench: cut-through instance under directed and random traffic,
// plus a store-and-forward instance for whole-packet release.
module tb_noc_vchannel_buffer_mux;

    localparam int CHANNELS = 2;

    typedef struct {
        int          cyc;
        int          ch;
        logic [31:0] flit;
        logic        last;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [CHANNELS-1:0][31:0] a_in_flit, b_in_flit;
    logic [CHANNELS-1:0]       a_in_last, a_in_valid, a_in_ready;
    logic [CHANNELS-1:0]       b_in_last, b_in_valid, b_in_ready;
    logic [31:0]               a_out_flit, b_out_flit;
    logic                      a_out_last, a_out_valid, a_out_ready;
    logic                      b_out_last, b_out_valid, b_out_ready;
    logic [0:0]                a_out_channel, b_out_channel;
    logic [CHANNELS-1:0][2:0]  a_fill, b_fill;

    noc_vchannel_buffer_mux #(.FLIT_WIDTH(32), .CHANNELS(CHANNELS), .DEPTH(4), .FULLPACKET(0)) dut_a (
        .clk(clk), .rst(rst), .in_flit(a_in_flit), .in_last(a_in_last), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_flit(a_out_flit), .out_last(a_out_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_channel(a_out_channel), .fill(a_fill));

    noc_vchannel_buffer_mux #(.FLIT_WIDTH(32), .CHANNELS(CHANNELS), .DEPTH(4), .FULLPACKET(1)) dut_b (
        .clk(clk), .rst(rst), .in_flit(b_in_flit), .in_last(b_in_last), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_flit(b_out_flit), .out_last(b_out_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_channel(b_out_channel), .fill(b_fill));

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] src_q [CHANNELS][$];
    logic [32:0] exp_q [CHANNELS][$];
    logic [32:0] mdl_q [CHANNELS][$];
    logic [32:0] cur   [CHANNELS];
    bit          cur_v [CHANNELS];
    int          mdl_ptr = CHANNELS - 1;
    bit          rand_src = 1'b0, rand_snk = 1'b0, fix_rdy = 1'b1;
    int          acc_cyc[$];
    xfer_t       a_log[$], b_log[$];
    int          b_acc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int c, input logic [31:0] f, input logic l);
        src_q[c].push_back({l, f});
        mdl_q[c].push_back({l, f});
    endtask

    // Reference: serve whole packets, next channel after the last one served.
    task automatic rr_model(output logic [32:0] seq[$], output int chs[$]);
        bit any;
        seq.delete();
        chs.delete();
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 1; i <= CHANNELS && !any; i++) begin
                int c;
                logic [32:0] f;
                c = (mdl_ptr + i) % CHANNELS;
                if (mdl_q[c].size() > 0) begin
                    any = 1'b1;
                    mdl_ptr = c;
                    do begin
                        f = mdl_q[c].pop_front();
                        seq.push_back(f);
                        chs.push_back(c);
                    end while (!f[32] && mdl_q[c].size() > 0);
                end
            end
        end
    endtask

    task automatic expect_seq(input string nm);
        logic [32:0] seq[$];
        int chs[$];
        rr_model(seq, chs);
        check({nm, "_len"}, 64'(a_log.size()), 64'(seq.size()));
        for (int i = 0; i < seq.size() && i < a_log.size(); i++) begin
            check(nm, 64'({a_log[i].ch[7:0], a_log[i].last, a_log[i].flit}), 64'({chs[i][7:0], seq[i]}));
            if (i > 0)
                check({nm, "_gap"}, 64'(a_log[i].cyc - a_log[i-1].cyc), seq[i-1][32] ? 64'd2 : 64'd1);
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int t;
        t = 0;
        while (a_log.size() < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("wait_log", 64'(a_log.size() >= n), 64'd1);
    endtask

    task automatic clear_logs();
        a_log.delete();
        b_log.delete();
        acc_cyc.delete();
    endtask

    task automatic b_push(input logic [31:0] f, input logic l);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        b_in_valid[0] = 1'b1;
        b_in_flit[0]  = f;
        b_in_last[0]  = l;
        while (!done && t < 50) begin
            done = b_in_ready[0];
            if (done) b_acc = cyc;
            @(posedge clk); #1;
            t++;
        end
        check("b_push", 64'(done), 64'd1);
        b_in_valid[0] = 1'b0;
        b_in_flit[0]  = '0;
        b_in_last[0]  = 1'b0;
    endtask

    // Source/sink driver for instance A: holds each flit until it is taken.
    initial begin
        logic [CHANNELS-1:0] rdy;
        a_in_valid = '0; a_in_flit = '0; a_in_last = '0; a_out_ready = 1'b0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < CHANNELS; c++) begin
                if (rst) cur_v[c] = 1'b0;
                else if (!cur_v[c] && src_q[c].size() > 0 && (!rand_src || $urandom_range(0, 3) != 0)) begin
                    cur[c]   = src_q[c].pop_front();
                    cur_v[c] = 1'b1;
                end
                a_in_valid[c] = cur_v[c];
                a_in_flit[c]  = cur_v[c] ? cur[c][31:0] : '0;
                a_in_last[c]  = cur_v[c] && cur[c][32];
            end
            a_out_ready = rand_snk ? ($urandom_range(0, 2) != 0) : fix_rdy;
            rdy = a_in_ready;
            @(posedge clk);
            for (int c = 0; c < CHANNELS; c++) begin
                if (cur_v[c] && rdy[c] && !rst) begin
                    exp_q[c].push_back(cur[c]);
                    acc_cyc.push_back(cyc);
                    cur_v[c] = 1'b0;
                end
            end
        end
    end

    // Monitor A: scoreboard pop per transfer, packet atomicity, hold under stall.
    initial begin
        bit          in_pkt, stall;
        int          cur_ch, ch;
        logic [33:0] held;
        logic [32:0] e;
        in_pkt = 1'b0; stall = 1'b0; cur_ch = 0; held = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                in_pkt = 1'b0;
                stall  = 1'b0;
            end else begin
                if (stall)
                    check("hold", 64'({a_out_valid, a_out_channel, a_out_last, a_out_flit}), 64'({1'b1, held}));
                if (!a_out_valid) check("idle_zero", 64'({a_out_last, a_out_flit}), 64'd0);
                else begin
                    ch = int'(a_out_channel);
                    if (in_pkt) check("atomic_ch", 64'(ch), 64'(cur_ch));
                    if (a_out_ready) begin
                        check("sb_avail", 64'(exp_q[ch].size() > 0), 64'd1);
                        if (exp_q[ch].size() > 0) begin
                            e = exp_q[ch].pop_front();
                            check("sb_flit", 64'({a_out_last, a_out_flit}), 64'(e));
                        end
                        a_log.push_back('{cyc, ch, a_out_flit, a_out_last});
                        in_pkt = !a_out_last;
                        cur_ch = ch;
                    end
                end
                stall = a_out_valid && !a_out_ready;
                held  = {a_out_channel, a_out_last, a_out_flit};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                if (!b_out_valid) check("b_idle_zero", 64'({b_out_last, b_out_flit}), 64'd0);
                else if (b_out_ready)
                    b_log.push_back('{cyc, int'(b_out_channel), b_out_flit, b_out_last});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, total, c, len;
        b_in_valid = '0; b_in_flit = '0; b_in_last = '0; b_out_ready = 1'b1;
        rst = 1'b1;
        #3;
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_out_valid", 64'({a_out_valid, b_out_valid}), 64'd0);
        check("rst_out_data", 64'({a_out_channel, a_out_last, a_out_flit}), 64'd0);
        check("rst_fill", 64'({a_fill, b_fill}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rel_in_ready", 64'({a_in_ready, b_in_ready}), 64'hF);

        // Single 3-flit packet on ch0.
        clear_logs();
        add(0, 32'hA0, 1'b0); add(0, 32'hA1, 1'b0); add(0, 32'hA2, 1'b1);
        wait_log(3, 40);
        if (a_log.size() > 0 && acc_cyc.size() > 0)
            check("latency", 64'(a_log[0].cyc), 64'(acc_cyc[0] + 2));
        expect_seq("single");
        repeat (2) @(posedge clk); #1;
        check("single_fill", 64'(a_fill[0]), 64'd0);

        // Round-robin over two buffered packets per channel.
        clear_logs();
        fix_rdy = 1'b0;
        add(0, 32'h10, 1'b0); add(0, 32'h11, 1'b1); add(0, 32'h12, 1'b0); add(0, 32'h13, 1'b1);
        add(1, 32'h20, 1'b0); add(1, 32'h21, 1'b1); add(1, 32'h22, 1'b0); add(1, 32'h23, 1'b1);
        repeat (10) @(posedge clk); #1;
        check("fair_fill", 64'(a_fill), 64'({3'd4, 3'd4}));
        k = (mdl_ptr + 1) % CHANNELS;
        check("fair_first", 64'({a_out_valid, a_out_channel, a_out_flit}), 64'({1'b1, k[0], mdl_q[k][0][31:0]}));
        fix_rdy = 1'b1;
        wait_log(8, 60);
        expect_seq("fair");

        // Backpressure fills ch0, then drains in order.
        clear_logs();
        fix_rdy = 1'b0;
        for (int j = 0; j < 6; j++) add(0, 32'h30 + j, j == 5);
        repeat (10) @(posedge clk); #1;
        check("bp_fill", 64'(a_fill[0]), 64'd4);
        check("bp_in_ready", 64'(a_in_ready[0]), 64'd0);
        check("bp_accepted", 64'(exp_q[0].size()), 64'd4);
        check("bp_head", 64'({a_out_valid, a_out_flit}), 64'({1'b1, 32'h30}));
        fix_rdy = 1'b1;
        wait_log(6, 60);
        expect_seq("bp");

        // Push-with-last and pop-with-last on ch1 in the same cycle.
        repeat (3) @(posedge clk); #1;
        clear_logs();
        add(1, 32'h40, 1'b1);
        k = 0;
        while (acc_cyc.size() < 1 && k < 20) begin @(posedge clk); #1; k++; end
        check("pp_acc", 64'(acc_cyc.size()), 64'd1);
        @(posedge clk); #1;
        add(1, 32'h41, 1'b1);
        @(posedge clk); #1;
        check("pp_lcnt", 64'(dut_a.g_ch[1].u_fifo.lcnt), 64'd1);
        if (acc_cyc.size() > 1) check("pp_same_edge", 64'(acc_cyc[1]), 64'(acc_cyc[0] + 2));
        wait_log(2, 20);
        expect_seq("pp");

        // Asynchronous reset during the second flit of four.
        repeat (3) @(posedge clk); #1;
        clear_logs();
        for (int j = 0; j < 4; j++) add(0, 32'h60 + j, j == 3);
        wait_log(1, 20);
        rst = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            src_q[i].delete(); exp_q[i].delete(); mdl_q[i].delete();
        end
        mdl_ptr = CHANNELS - 1;
        #1;
        check("arst_out", 64'({a_out_valid, a_out_channel, a_out_last, a_out_flit}), 64'd0);
        check("arst_fill", 64'(a_fill), 64'd0);
        check("arst_in_ready", 64'(a_in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        add(0, 32'h55, 1'b1);
        wait_log(1, 20);
        repeat (6) @(posedge clk); #1;
        expect_seq("arst_pkt");

        // Random traffic on both channels with random sink stalls.
        clear_logs();
        rand_src = 1'b1; rand_snk = 1'b1;
        total = 0;
        for (int p = 0; p < 40; p++) begin
            c   = int'($urandom_range(0, CHANNELS - 1));
            len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) src_q[c].push_back({j == len - 1, $urandom});
            total += len;
        end
        wait_log(total, 4000);
        check("rand_drain", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
        rand_src = 1'b0; rand_snk = 1'b0;

        // Store-and-forward: nothing leaves until the last flit is in.
        b_log.delete();
        b_push(32'hB0, 1'b0); repeat (2) @(posedge clk); #1;
        b_push(32'hB1, 1'b0); repeat (2) @(posedge clk); #1;
        b_push(32'hB2, 1'b1);
        k = b_acc;
        check("sf_held", 64'(b_log.size()), 64'd0);
        repeat (8) @(posedge clk); #1;
        check("sf_len", 64'(b_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < b_log.size(); i++)
            check("sf_flit", 64'({b_log[i].cyc[15:0], b_log[i].last, b_log[i].flit}),
                  64'({16'(k + 2 + i), i == 2, 32'hB0 + 32'(i)}));

        // Packet longer than DEPTH goes out through the full-FIFO fallback.
        b_log.delete();
        for (int j = 0; j < 6; j++) b_push(32'hC0 + j, j == 5);
        k = 0;
        while (b_log.size() < 6 && k < 30) begin @(posedge clk); #1; k++; end
        check("sf_long_len", 64'(b_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < b_log.size(); i++)
            check("sf_long", 64'({b_log[i].ch[7:0], b_log[i].last, b_log[i].flit}),
                  64'({8'd0, i == 5, 32'hC0 + 32'(i)}));
        check("sf_fill", 64'(b_fill), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/noc_vchannel_buffer_mux.md
Name: noc_vchannel_buffer_mux

Overview:
Per-endpoint egress stage that buffers CHANNELS independent flit streams (flit/last/valid/ready) in per-channel FIFOs and merges them onto one physical link. The merge is packet-atomic and round-robin. It sits between a NoC node's virtual channels and the shared inter-router link. It generalises the flat per-node/per-channel link bundle with depth, channel count and a store-and-forward mode.

Parameters:
- FLIT_WIDTH, 32: flit payload width.
- CHANNELS, 2: number of input channels, >=1.
- DEPTH, 4: per-channel FIFO depth; power of 2, >=2.
- FULLPACKET, 0: 0 = cut-through, 1 = store-and-forward.
- Derived constants:
  - CW = max(1, $clog2(CHANNELS)).
  - FW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_flit  in  [CHANNELS-1:0][FLIT_WIDTH-1:0]  per-channel flit.
- in_last  in  [CHANNELS-1:0]  last flit of packet.
- in_valid  in  [CHANNELS-1:0]  flit valid.
- in_ready  out  [CHANNELS-1:0]  channel can accept.
- out_flit  out  [FLIT_WIDTH-1:0]  merged flit.
- out_last  out  1  merged last.
- out_valid  out  1  merged valid.
- out_ready  in  1  downstream accept.
- out_channel  out  [CW-1:0]  source channel of the current out flit.
- fill  out  [CHANNELS-1:0][FW-1:0]  per-channel occupancy.

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high. All state is cleared on rst assertion, without waiting for a clock edge.
- Reset values:
  - All FIFOs empty; fill = 0.
  - Last-counters = 0.
  - FSM = IDLE.
  - rr_ptr = CHANNELS-1, so channel 0 has first priority.
  - out_valid = 0; out_flit = 0; out_last = 0; out_channel = 0.
  - in_ready = 0 while rst is high, all 1 on the first cycle after release.
- Push rules:
  - Push on channel c when in_valid[c] && in_ready[c]; the flit is written at that edge.
  - in_ready[c] = !full[c], derived from the registered count.
  - No same-cycle bypass: a full FIFO that is being popped still shows in_ready = 0 in that cycle.
  - Flits presented while in_ready = 0 are not taken. The source must hold them; the block does not check this.
- Pop: on out_valid && out_ready, from FIFO[sel].
- Last-counter lcnt[c] (width FW):
  - +1 on a push with last; -1 on a pop with last.
  - Push-with-last and pop-with-last in the same cycle: unchanged.
- Eligibility:
  - FULLPACKET = 0: FIFO non-empty.
  - FULLPACKET = 1: lcnt[c] > 0, or FIFO full. The full case is a cut-through fallback for packets longer than DEPTH and prevents deadlock.
- FSM:
  - IDLE: if any channel is eligible, pick the first eligible in round-robin order starting at rr_ptr+1 (mod CHANNELS). Register sel and go to LOCKED. Otherwise stay in IDLE.
  - LOCKED:
    - out_valid = !empty[sel]; out_flit/out_last = FIFO[sel] head; out_channel = sel.
    - On a transfer with out_last = 1: rr_ptr <= sel, go to IDLE.
    - Other channels are never interleaved inside a packet.
    - If FIFO[sel] drains mid-packet (cut-through), out_valid drops and the FSM stays LOCKED.
- Output values:
  - out_flit and out_last are 0 whenever out_valid = 0.
  - When out_valid = 1 and out_ready = 0, out_flit/out_last/out_channel stay stable until the transfer.
- Latency:
  - Into an idle block: a flit pushed at edge k is presented on out at cycle k+1 after the grant edge, i.e. out_valid is first high in the cycle after edge k+1.
  - Between packets: exactly one idle bubble cycle (the IDLE grant cycle).
- Throughput: one flit per cycle within a packet.
- Pointer width: FIFO pointers wrap modulo DEPTH, using log2(DEPTH) bits.
- Single-channel case: CHANNELS = 1 degenerates to a FIFO with one bubble per packet; out_channel = 0.
- Reset mid-packet: in-flight flits are discarded and no partial packet is re-emitted after release. Upstream and downstream must also reset.

Decomposition:
- Package noc_pkg:
  - function clog2_min1 (computes CW/FW).
  - typedef flit_t (logic [FLIT_WIDTH-1:0]), parameterised via the module.
  - enum arb_state_e {IDLE, LOCKED}.
- Sub-module noc_vchannel_fifo:
  - Single-channel FIFO of depth DEPTH, width FLIT_WIDTH+1 (flit plus last).
  - Outputs full, empty, fill and lcnt.
  - Instantiated CHANNELS times via generate.
- Top level holds the round-robin arbiter, FSM and output mux.

Test Plan:
- Reset then single packet: CHANNELS=2. Channel 0 pushes 3 flits 0xA0..0xA2, last on 0xA2, out_ready=1 -> out carries 0xA0,0xA1,0xA2 on consecutive cycles with out_last only on 0xA2, out_channel=0, fill[0] returns to 0.
- Round-robin fairness: both channels hold two 2-flit packets each (ch0: 0x10/0x11, 0x12/0x13; ch1: 0x20/0x21, 0x22/0x23) -> output packet order is ch0, ch1, ch0, ch1, with no interleaving within a packet and one bubble between packets.
- Backpressure and full: DEPTH=4, out_ready=0, ch0 pushes 6 flits -> in_ready[0] drops after the 4th flit, fill[0]=4, out_flit held stable. Release out_ready -> all 6 flits delivered in order.
- Store-and-forward: FULLPACKET=1. Ch0 pushes 3 flits with 2-cycle gaps -> out_valid stays 0 until the edge after the last flit's push, then 3 back-to-back flits. A 6-flit packet with DEPTH=4 completes via the full-FIFO fallback.
- Simultaneous push/pop with last: a 1-flit packet pushed on ch1 in the same cycle that ch1's previous 1-flit packet is popped -> lcnt[1] unchanged at 1, and the second packet follows after one bubble.
- Asynchronous reset mid-packet: assert rst between clock edges during flit 2 of 4 -> out_valid and fill go to 0 immediately. After release, a new packet 0x55 is delivered alone, from channel 0.
